// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : One-cycle registered 16-bit ALU (add/sub/logic/shift/rotate/
//            branch compare); multiply/divide only when ALU_MULDIV_EN is defined.
// Revision : 1.0
// ============================================================================
module alu (
  input  logic               clk,
  input  logic               rst,
  input  logic        [3:0]  funct,
  input  logic signed [15:0] Rout1,
  input  logic signed [15:0] Rout2,
  output logic signed [15:0] R0,
  output logic signed [15:0] result,
  output logic               branch
);

  localparam logic [3:0] F_NOP0 = 4'h0;
  localparam logic [3:0] F_MUL  = 4'h1;
  localparam logic [3:0] F_DIV  = 4'h2;
  localparam logic [3:0] F_NOP3 = 4'h3;
  localparam logic [3:0] F_BEQ  = 4'h4;
  localparam logic [3:0] F_BNE  = 4'h5;
  localparam logic [3:0] F_BLT  = 4'h6;
  localparam logic [3:0] F_BGT  = 4'h7;
  localparam logic [3:0] F_ROL  = 4'h8;
  localparam logic [3:0] F_ROR  = 4'h9;
  localparam logic [3:0] F_SLL  = 4'hA;
  localparam logic [3:0] F_SRL  = 4'hB;
  localparam logic [3:0] F_OR   = 4'hC;
  localparam logic [3:0] F_AND  = 4'hD;
  localparam logic [3:0] F_SUB  = 4'hE;
  localparam logic [3:0] F_ADD  = 4'hF;

  logic [15:0] amt;
  logic [15:0] a_u;
  logic [4:0]  rot_inv;
  logic        big_shift;

  logic [15:0] next_result;
  logic [15:0] next_r0;
  logic        next_branch;

  assign amt       = $unsigned(Rout2);
  assign a_u       = $unsigned(Rout1);
  assign big_shift = |amt[15:4];
  // Complementary shift for rotates; an amount of 0 yields 16, which clears that term.
  assign rot_inv   = 5'd16 - {1'b0, amt[3:0]};

`ifdef ALU_MULDIV_EN
  logic signed [31:0] product;
  assign product = $signed({{16{Rout1[15]}}, Rout1}) * $signed({{16{Rout2[15]}}, Rout2});
`endif

  always_comb begin
    next_result = 16'h0000;
    next_r0     = 16'h0000;
    next_branch = 1'b0;
    case (funct)
      F_ADD: next_result = a_u + amt;
      F_SUB: next_result = a_u - amt;
      F_AND: next_result = a_u & amt;
      F_OR:  next_result = a_u | amt;
      F_SLL: next_result = big_shift ? 16'h0000 : (a_u << amt[3:0]);
      F_SRL: next_result = big_shift ? 16'h0000 : (a_u >> amt[3:0]);
      F_ROL: next_result = (a_u << amt[3:0]) | (a_u >> rot_inv);
      F_ROR: next_result = (a_u >> amt[3:0]) | (a_u << rot_inv);
      F_BEQ: next_branch = (Rout1 == Rout2);
      F_BNE: next_branch = (Rout1 != Rout2);
      F_BLT: next_branch = (Rout1 < Rout2);
      F_BGT: next_branch = (Rout1 > Rout2);
`ifdef ALU_MULDIV_EN
      F_MUL: begin
        next_result = product[15:0];
        next_r0     = product[31:16];
      end
      F_DIV: begin
        // Zero divisor and the single overflow case are resolved explicitly.
        if (Rout2 == 16'sd0) begin
          next_result = 16'hFFFF;
          next_r0     = a_u;
        end else if (Rout1 == -16'sd32768 && Rout2 == -16'sd1) begin
          next_result = 16'h8000;
          next_r0     = 16'h0000;
        end else begin
          next_result = $unsigned(Rout1 / Rout2);
          next_r0     = $unsigned(Rout1 % Rout2);
        end
      end
`else
      F_MUL, F_DIV: begin
        next_result = 16'h0000;
        next_r0     = 16'h0000;
      end
`endif
      F_NOP0, F_NOP3: next_result = 16'h0000;
      default:        next_result = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= 16'sh0000;
      R0     <= 16'sh0000;
      branch <= 1'b0;
    end else begin
      result <= $signed(next_result);
      R0     <= $signed(next_r0);
      branch <= next_branch;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Directed self-checking bench for alu (set ALU_MULDIV_EN to match DUT).
// Revision : 1.0
// ============================================================================
module tb_alu;

  logic               clk;
  logic               rst;
  logic        [3:0]  funct;
  logic signed [15:0] Rout1;
  logic signed [15:0] Rout2;
  logic signed [15:0] R0;
  logic signed [15:0] result;
  logic               branch;

  int n_checks = 0;
  int n_fails  = 0;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .funct  (funct),
    .Rout1  (Rout1),
    .Rout2  (Rout2),
    .R0     (R0),
    .result (result),
    .branch (branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {funct, a, b, exp_r0, exp_result, exp_branch}
  typedef logic [68:0] vec_t;

  task automatic apply(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    funct = f;
    Rout1 = a;
    Rout2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    funct = 4'hF;
    Rout1 = 16'h1234;
    Rout2 = 16'h1111;
    #3;
    n_checks++;
    if ({R0, result, branch} !== 33'h0) begin
      n_fails++;
      $display("FAIL reset_initial: got R0=%h result=%h branch=%b, expected all zero", R0, result, branch);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({R0, result, branch} !== 33'h0) begin
      n_fails++;
      $display("FAIL reset_held_edge: got R0=%h result=%h branch=%b, expected all zero", R0, result, branch);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_addsub_logic;
    vec_t v [8];
    v = '{
      {4'hF, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h5554, 1'b0},
      {4'hE, 16'hFFFB, 16'h0002, 16'h0000, 16'hFFF9, 1'b0},
      {4'hF, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 1'b0},
      {4'hE, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 1'b0},
      {4'hD, 16'h0005, 16'h0007, 16'h0000, 16'h0005, 1'b0},
      {4'hC, 16'h0005, 16'h0008, 16'h0000, 16'h000D, 1'b0},
      {4'h0, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 1'b0},
      {4'h3, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0}
    };
    for (int i = 0; i < 8; i++) begin
      apply(v[i][68:65], v[i][64:49], v[i][48:33]);
      n_checks++;
      if ({R0, result, branch} !== v[i][32:0]) begin
        n_fails++;
        $display("FAIL addsub_logic[%0d]: got R0=%h result=%h branch=%b, expected R0=%h result=%h branch=%b",
                 i, R0, result, branch, v[i][32:17], v[i][16:1], v[i][0]);
      end
    end
  endtask

  task automatic test_muldiv;
    vec_t v [7];
`ifdef ALU_MULDIV_EN
    v = '{
      {4'h1, 16'h0005, 16'h0004, 16'h0000, 16'h0014, 1'b0},
      {4'h1, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0},
      {4'h1, 16'd300,  16'd300,  16'h0001, 16'h5F90, 1'b0},
      {4'h2, 16'h0005, 16'h0004, 16'h0001, 16'h0001, 1'b0},
      {4'h2, 16'h0007, 16'h0000, 16'h0007, 16'hFFFF, 1'b0},
      {4'h2, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0},
      {4'h2, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0}
    };
`else
    v = '{
      {4'h1, 16'h0005, 16'h0004, 16'h0000, 16'h0000, 1'b0},
      {4'h1, 16'hFFFD, 16'h0005, 16'h0000, 16'h0000, 1'b0},
      {4'h1, 16'd300,  16'd300,  16'h0000, 16'h0000, 1'b0},
      {4'h2, 16'h0005, 16'h0004, 16'h0000, 16'h0000, 1'b0},
      {4'h2, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 1'b0},
      {4'h2, 16'hFFF9, 16'h0002, 16'h0000, 16'h0000, 1'b0},
      {4'h2, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0}
    };
`endif
    for (int i = 0; i < 7; i++) begin
      apply(v[i][68:65], v[i][64:49], v[i][48:33]);
      n_checks++;
      if ({R0, result, branch} !== v[i][32:0]) begin
        n_fails++;
        $display("FAIL muldiv[%0d]: got R0=%h result=%h branch=%b, expected R0=%h result=%h branch=%b",
                 i, R0, result, branch, v[i][32:17], v[i][16:1], v[i][0]);
      end
    end
  endtask

  task automatic test_shift_rotate;
    vec_t v [10];
    v = '{
      {4'hA, 16'h0005, 16'd4,    16'h0000, 16'h0050, 1'b0},
      {4'hB, 16'h0005, 16'd4,    16'h0000, 16'h0000, 1'b0},
      {4'h8, 16'h0005, 16'd4,    16'h0000, 16'h0050, 1'b0},
      {4'h9, 16'h0005, 16'd4,    16'h0000, 16'h5000, 1'b0},
      {4'h9, 16'h0005, 16'd16,   16'h0000, 16'h0005, 1'b0},
      {4'h9, 16'h0005, 16'd18,   16'h0000, 16'h4001, 1'b0},
      {4'hA, 16'h0005, 16'd16,   16'h0000, 16'h0000, 1'b0},
      {4'hB, 16'h8000, 16'd15,   16'h0000, 16'h0001, 1'b0},
      {4'hA, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1'b0},
      {4'h8, 16'h8001, 16'd1,    16'h0000, 16'h0003, 1'b0}
    };
    for (int i = 0; i < 10; i++) begin
      apply(v[i][68:65], v[i][64:49], v[i][48:33]);
      n_checks++;
      if ({R0, result, branch} !== v[i][32:0]) begin
        n_fails++;
        $display("FAIL shift_rotate[%0d]: got R0=%h result=%h branch=%b, expected R0=%h result=%h branch=%b",
                 i, R0, result, branch, v[i][32:17], v[i][16:1], v[i][0]);
      end
    end
  endtask

  task automatic test_branch;
    vec_t v [7];
    v = '{
      {4'h4, 16'd3,    16'd3,    16'h0000, 16'h0000, 1'b1},
      {4'h5, 16'd3,    16'd3,    16'h0000, 16'h0000, 1'b0},
      {4'h6, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1},
      {4'h7, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0},
      {4'h7, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1},
      {4'h6, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 1'b1},
      {4'h5, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 1'b1}
    };
    for (int i = 0; i < 7; i++) begin
      apply(v[i][68:65], v[i][64:49], v[i][48:33]);
      n_checks++;
      if ({R0, result, branch} !== v[i][32:0]) begin
        n_fails++;
        $display("FAIL branch[%0d]: got R0=%h result=%h branch=%b, expected R0=%h result=%h branch=%b",
                 i, R0, result, branch, v[i][32:17], v[i][16:1], v[i][0]);
      end
    end
  endtask

  // Alternates branch and arithmetic ops so stale branch/result bits would show.
  task automatic test_back_to_back;
    vec_t v [6];
    v = '{
      {4'h4, 16'd9,    16'd9,    16'h0000, 16'h0000, 1'b1},
      {4'hF, 16'd9,    16'd9,    16'h0000, 16'h0012, 1'b0},
      {4'h7, 16'd10,   16'd9,    16'h0000, 16'h0000, 1'b1},
      {4'hC, 16'hF000, 16'h000F, 16'h0000, 16'hF00F, 1'b0},
      {4'h0, 16'hF000, 16'h000F, 16'h0000, 16'h0000, 1'b0},
      {4'hE, 16'h8000, 16'h0001, 16'h0000, 16'h7FFF, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      apply(v[i][68:65], v[i][64:49], v[i][48:33]);
      n_checks++;
      if ({R0, result, branch} !== v[i][32:0]) begin
        n_fails++;
        $display("FAIL back_to_back[%0d]: got R0=%h result=%h branch=%b, expected R0=%h result=%h branch=%b",
                 i, R0, result, branch, v[i][32:17], v[i][16:1], v[i][0]);
      end
    end
  endtask

  task automatic test_async_reset;
    apply(4'hF, 16'h0001, 16'h0002);
    n_checks++;
    if (result !== 16'sh0003) begin
      n_fails++;
      $display("FAIL async_pre: got result=%h, expected 0003", result);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({R0, result, branch} !== 33'h0) begin
      n_fails++;
      $display("FAIL async_assert: got R0=%h result=%h branch=%b, expected all zero", R0, result, branch);
    end
    apply(4'h4, 16'd3, 16'd3);
    n_checks++;
    if ({R0, result, branch} !== 33'h0) begin
      n_fails++;
      $display("FAIL async_held: got R0=%h result=%h branch=%b, expected all zero", R0, result, branch);
    end
    @(negedge clk);
    rst   = 1'b0;
    funct = 4'hD;
    Rout1 = 16'h0005;
    Rout2 = 16'h0007;
    @(posedge clk);
    #1;
    n_checks++;
    if ({R0, result, branch} !== {16'h0000, 16'h0005, 1'b0}) begin
      n_fails++;
      $display("FAIL async_release: got R0=%h result=%h branch=%b, expected R0=0000 result=0005 branch=0",
               R0, result, branch);
    end
  endtask

  initial begin
    test_reset();
    test_addsub_logic();
    test_muldiv();
    test_shift_rotate();
    test_branch();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
